// File: rtl/mips_pkg.sv
// Shared MIPS decode/execute constants: opcodes, funct codes,
// ALU operation codes, alu_op encodings and the control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_exec_decode_if.sv
// Decode/execute bus: instruction fields and operands in,
// control lines, ALU result/zero and registered copies out.
// master drives opcode/funct/operands; slave is the core.
interface mips_exec_decode_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] read1;
    logic [WIDTH-1:0] read2;
    logic [WIDTH-1:0] imm_ext;
    logic             reg_dst;
    logic             branch;
    logic             mem_read;
    logic             mem_to_reg;
    logic             mem_write;
    logic             alu_src;
    logic             reg_write;
    logic             jump;
    logic [1:0]       alu_op;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    modport master (
        output opcode, funct, read1, read2, imm_ext,
        input  reg_dst, branch, mem_read, mem_to_reg, mem_write,
        input  alu_src, reg_write, jump, alu_op, alu_ctrl,
        input  result, zero, result_q, zero_q
    );

    modport slave (
        input  opcode, funct, read1, read2, imm_ext,
        output reg_dst, branch, mem_read, mem_to_reg, mem_write,
        output alu_src, reg_write, jump, alu_op, alu_ctrl,
        output result, zero, result_q, zero_q
    );
endinterface

// File: rtl/mips_alu.sv
// 32-bit MIPS ALU with zero flag.
// Ports: i_ctrl (4b op), i_a, i_b -> o_result, o_zero.
module mips_alu
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    logic w_lt;

    assign w_lt = $signed(i_a) < $signed(i_b);

    always_comb begin
        o_result = '0;
        unique case (i_ctrl)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
            ALU_NOR: o_result = ~(i_a | i_b);
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/mips_exec_decode.sv
// Single-cycle MIPS decode/execute: main decoder, ALU control
// and ALU; result/zero also registered for observation.
// Ports: clk, rst (async, active high), bus (slave modport).
module mips_exec_decode
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    mips_exec_decode_if.slave bus
);

    ctrl_t            w_ctrl;
    logic [3:0]       w_alu_ctrl;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic [WIDTH-1:0] r_result_q;
    logic             r_zero_q;

    // Unlisted opcodes decode to all-zero controls (NOP).
    always_comb begin
        w_ctrl = '0;
        unique case (1'b1)
            (bus.opcode == OP_RTYPE):
                w_ctrl = '{1'b1, 1'b0, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b0, ALUOP_RTYPE};
            (bus.opcode == OP_LW):
                w_ctrl = '{1'b0, 1'b1, 1'b1, 1'b1,
                           1'b1, 1'b0, 1'b0, 1'b0, ALUOP_ADD};
            (bus.opcode == OP_SW):
                w_ctrl = '{1'b0, 1'b1, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
            (bus.opcode == OP_BEQ):
                w_ctrl = '{1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b1, 1'b0, ALUOP_SUB};
            (bus.opcode == OP_ADDI):
                w_ctrl = '{1'b0, 1'b1, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD};
            (bus.opcode == OP_J):
                w_ctrl = '{1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b1, ALUOP_ADD};
            default: w_ctrl = '0;
        endcase
    end

    // alu_op 11 is unused and falls back to add.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        unique case (w_ctrl.alu_op)
            ALUOP_ADD: w_alu_ctrl = ALU_ADD;
            ALUOP_SUB: w_alu_ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                unique case (bus.funct)
                    FN_ADD:  w_alu_ctrl = ALU_ADD;
                    FN_SUB:  w_alu_ctrl = ALU_SUB;
                    FN_AND:  w_alu_ctrl = ALU_AND;
                    FN_OR:   w_alu_ctrl = ALU_OR;
                    FN_NOR:  w_alu_ctrl = ALU_NOR;
                    FN_SLT:  w_alu_ctrl = ALU_SLT;
                    default: w_alu_ctrl = ALU_BAD;
                endcase
            end
            default: w_alu_ctrl = ALU_ADD;
        endcase
    end

    assign w_b = w_ctrl.alu_src ? bus.imm_ext : bus.read2;

    mips_alu #(.WIDTH(WIDTH)) u_alu (
        .i_ctrl   (w_alu_ctrl),
        .i_a      (bus.read1),
        .i_b      (w_b),
        .o_result (w_result),
        .o_zero   (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result_q <= '0;
            r_zero_q   <= 1'b0;
        end else begin
            r_result_q <= w_result;
            r_zero_q   <= w_zero;
        end
    end

    assign bus.reg_dst    = w_ctrl.reg_dst;
    assign bus.alu_src    = w_ctrl.alu_src;
    assign bus.mem_to_reg = w_ctrl.mem_to_reg;
    assign bus.reg_write  = w_ctrl.reg_write;
    assign bus.mem_read   = w_ctrl.mem_read;
    assign bus.mem_write  = w_ctrl.mem_write;
    assign bus.branch     = w_ctrl.branch;
    assign bus.jump       = w_ctrl.jump;
    assign bus.alu_op     = w_ctrl.alu_op;
    assign bus.alu_ctrl   = w_alu_ctrl;
    assign bus.result     = w_result;
    assign bus.zero       = w_zero;
    assign bus.result_q   = r_result_q;
    assign bus.zero_q     = r_zero_q;

endmodule

// File: tb/tb_mips_exec_decode.sv
// Self-checking bench for mips_exec_decode: directed cases
// plus randomized instructions against a behavioural model.
module tb_mips_exec_decode;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mips_exec_decode_if #(.WIDTH(32)) bus ();

    mips_exec_decode #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model state for the last applied instruction.
    logic [9:0]  m_ctrl;
    logic [3:0]  m_actl;
    logic [31:0] m_res;

    // Controls packed as {reg_dst,alu_src,mem_to_reg,reg_write,
    // mem_read,mem_write,branch,jump,alu_op[1:0]}.
    function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 10'b1001_0000_10;
            6'h23:   return 10'b0111_1000_00;
            6'h2B:   return 10'b0100_0100_00;
            6'h04:   return 10'b0000_0010_01;
            6'h08:   return 10'b0101_0000_00;
            6'h02:   return 10'b0000_0001_00;
            default: return 10'b0;
        endcase
    endfunction

    task automatic model(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] imm);
        logic [31:0] b;
        m_ctrl = ref_ctrl(op);
        b = m_ctrl[8] ? imm : r2;
        if (m_ctrl[1:0] == 2'b10) begin
            case (fn)
                6'h20: begin m_actl = 4'b0010; m_res = a + b; end
                6'h22: begin m_actl = 4'b0110; m_res = a - b; end
                6'h24: begin m_actl = 4'b0000; m_res = a & b; end
                6'h25: begin m_actl = 4'b0001; m_res = a | b; end
                6'h27: begin m_actl = 4'b1100; m_res = ~(a | b); end
                6'h2A: begin
                    m_actl = 4'b0111;
                    m_res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                end
                default: begin m_actl = 4'b1111; m_res = 32'd0; end
            endcase
        end else if (m_ctrl[1:0] == 2'b01) begin
            m_actl = 4'b0110;
            m_res = a - b;
        end else begin
            m_actl = 4'b0010;
            m_res = a + b;
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] imm);
        bus.opcode  = op;
        bus.funct   = fn;
        bus.read1   = a;
        bus.read2   = r2;
        bus.imm_ext = imm;
        model(op, fn, a, r2, imm);
        #1;
    endtask

    task automatic check_comb(input string tag);
        logic [9:0] got;
        got = {bus.reg_dst, bus.alu_src, bus.mem_to_reg,
               bus.reg_write, bus.mem_read, bus.mem_write,
               bus.branch, bus.jump, bus.alu_op};
        check({tag, ".ctrl"}, 32'(got), 32'(m_ctrl));
        check({tag, ".actl"}, 32'(bus.alu_ctrl), 32'(m_actl));
        check({tag, ".res"}, bus.result, m_res);
        check({tag, ".zero"}, 32'(bus.zero), 32'(m_res == 32'd0));
    endtask

    logic [5:0] ops [8];
    logic [5:0] fns [8];

    initial begin
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h11};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F, 6'h00};

        apply(6'h00, 6'h20, 32'd0, 32'd0, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset.result_q", bus.result_q, 32'd0);
        check("reset.zero_q", 32'(bus.zero_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: R-type add
        apply(6'h00, 6'h20, 32'd5, 32'd7, 32'd0);
        check_comb("t1");
        check("t1.actl_lit", 32'(bus.alu_ctrl), 32'h2);
        check("t1.res_lit", bus.result, 32'd12);
        check("t1.regdst", 32'(bus.reg_dst & bus.reg_write), 32'd1);

        // 2: beq equal / unequal
        apply(6'h04, 6'h00, 32'h1234, 32'h1234, 32'h0);
        check_comb("t2a");
        check("t2a.zero_lit", 32'(bus.zero), 32'd1);
        apply(6'h04, 6'h00, 32'h1234, 32'h1235, 32'h0);
        check_comb("t2b");
        check("t2b.zero_lit", 32'(bus.zero), 32'd0);

        // 3: signed slt both ways
        apply(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 32'h0);
        check("t3a.res_lit", bus.result, 32'd1);
        apply(6'h00, 6'h2A, 32'd1, 32'hFFFFFFFF, 32'h0);
        check("t3b.res_lit", bus.result, 32'd0);

        // 4: lw with negative offset
        apply(6'h23, 6'h00, 32'h100, 32'h55, 32'hFFFFFFFC);
        check_comb("t4");
        check("t4.res_lit", bus.result, 32'hFC);

        // 5: unknown opcode and unknown funct
        apply(6'h3F, 6'h3F, 32'h9, 32'h3, 32'h0);
        check_comb("t5a");
        apply(6'h00, 6'h3F, 32'h9, 32'h3, 32'h0);
        check_comb("t5b");
        check("t5b.actl_lit", 32'(bus.alu_ctrl), 32'hF);
        check("t5b.res_lit", bus.result, 32'd0);

        // 6: capture then async reset between edges
        @(negedge clk);
        apply(6'h00, 6'h20, 32'd5, 32'd7, 32'd0);
        @(posedge clk);
        #1;
        check("t6.result_q", bus.result_q, 32'd12);
        check("t6.zero_q", 32'(bus.zero_q), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("t6.rst_result_q", bus.result_q, 32'd0);
        @(posedge clk);
        #1;
        check("t6.hold_result_q", bus.result_q, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random instructions, comb and registered outputs.
        for (int i = 0; i < 300; i++) begin
            logic [5:0]  op;
            logic [5:0]  fn;
            logic [31:0] a;
            logic [31:0] r2;
            logic [31:0] imm;
            op  = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)]
                                             : 6'($urandom);
            fn  = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 7)]
                                             : 6'($urandom);
            a   = $urandom;
            r2  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 3) == 0) ? -a : $urandom;
            if ($urandom_range(0, 7) == 0) r2 = 32'h80000000;
            @(negedge clk);
            apply(op, fn, a, r2, imm);
            check_comb("rnd");
            @(posedge clk);
            #1;
            check("rnd.result_q", bus.result_q, m_res);
            check("rnd.zero_q", 32'(bus.zero_q), 32'(m_res == 32'd0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
